csr_counter_file: RTL and testbench
===================================

# csr_counter_file

Parametrised RISC-V counter CSR file: cycle, instret and optional hardware-performance counters with machine-mode read/write, user-mode read-only aliases and per-counter inhibit. It sits beside the decode/execute stage. It serves `csrrw`/`csrrs`/`csrrc` and their immediate forms with one-cycle registered read data and an illegal-access flag for trap generation.

## Interface
- `COUNTER_WIDTH`, 64: implemented bits per counter, 33..64; bits above read zero.
- `NUM_HPM`, 4: number of implemented `mhpmcounter3..` counters, 0..29.
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high.
- `csr_en  in  1`: CSR access this cycle.
- `csr_addr  in  12`: CSR address.
- `csr_op  in  2`: 00 read-only, 01 write, 10 set, 11 clear.
- `csr_wdata  in  32`: write/set/clear operand.
- `instret_inc  in  1`: one instruction retired this cycle.
- `hpm_event  in  NUM_HPM`: per-counter increment strobes.
- `rdata  out  32`: pre-access CSR value, registered.
- `illegal  out  1`: access illegal, registered with `rdata`.

## Operation
- Counters:
  - mcycle: +1 every cycle.
  - minstret: +1 when `instret_inc` is high.
  - mhpmcounter(3+i): +1 when `hpm_event[i]` is high.
  - All wrap modulo 2^COUNTER_WIDTH.
- Address map:
  - Machine low halves: mcycle 0xB00, minstret 0xB02, mhpmcounter3..31 0xB03..0xB1F.
  - Machine high halves: 0xB80/0xB82/0xB83..0xB9F.
  - mcountinhibit: 0x320.
  - User read-only aliases: cycle 0xC00, time 0xC01 (= cycle), instret 0xC02, hpmcounter 0xC03..0xC1F, high halves 0xC80..0xC9F.
- mcountinhibit:
  - bit0 inhibits cycle, bit2 inhibits instret, bit(3+i) inhibits hpm i.
  - Bit1 and bits for unimplemented counters are hardwired 0.
  - Reset value 0.
- Write value by `csr_op`:
  - 01: `csr_wdata`.
  - 10: old value OR `csr_wdata`.
  - 11: old value AND NOT `csr_wdata`.
  - 00: no write.
- A write to a low half changes only bits [31:0]; a write to a high half changes only bits [COUNTER_WIDTH-1:32].
- Write vs. increment in the same cycle: the write wins and that cycle's increment is dropped for that counter only.
- An inhibited counter holds its value but remains writable.
- Unimplemented hpm counters (index ≥ NUM_HPM) read 0 and ignore writes; these accesses are legal.
- `illegal` is set for:
  - an unmapped address, or
  - `csr_op` ≠ 00 to any 0xCxx alias.
- On an illegal access: `rdata` = 0 and no state changes.

## Timing
- Reset: all counters, mcountinhibit, `rdata` and `illegal` are 0.
- Latency: access in cycle N gives `rdata`/`illegal` valid in cycle N+1.
- When `csr_en` is low, `rdata` and `illegal` hold their previous values.
- `rdata` returns the value before any write in cycle N, and before cycle N's increment.
- A write in cycle N is visible to a read in cycle N+1.
- An inhibit write takes effect from cycle N+1; the counter still increments in cycle N per the old inhibit.
- Low-half wrap carries into the high half in the same cycle. Reading low then high can observe a carry in between; software handles this with the standard hi/lo/hi loop.
- Reset mid-operation clears all state in the next cycle; no pending access completes.

## Configuration
- `CSR_HPM_EN` defined: NUM_HPM hpm counters and their inhibit bits are implemented.
- `CSR_HPM_EN` undefined:
  - NUM_HPM is treated as 0: all hpm addresses read 0 and ignore writes, and inhibit bits 3..31 read 0.
  - The `hpm_event` port remains and is ignored.

## Structure
- Package `csr_pkg`:
  - address constants for all counters and mcountinhibit;
  - `csr_op_e` enum (READ, WRITE, SET, CLEAR);
  - inhibit bit indices.
- Sub-module `csr_counter`:
  - one COUNTER_WIDTH counter with `inc`, `inhibit`, `wr_lo`, `wr_hi` and `wdata`;
  - instantiated 2 + NUM_HPM times.
- Top level contains address decode, the op ALU, the read mux and the registered outputs.

## Test plan
- Counting and inhibit:
  - Stimulus: reset, run 10 cycles, read 0xC00.
  - Response: `rdata` = 10 (counting starts in the cycle after reset deasserts, so the read samples 10); `illegal` = 0.
  - Then write 0x320 = 0x1, wait 5 cycles, read twice: equal values.
- Carry and write precedence:
  - Stimulus: csrrw 0xB00 = 0xFFFF_FFFF, then read 0xB80 two cycles later.
  - Response: `rdata` = 1.
  - Also a write coinciding with `instret_inc` on 0xB02: the following read equals the written value.
- Set/clear:
  - Stimulus: write 0xB02 = 0xF0F0, then set 0x000F, then clear 0x00F0.
  - Response: reads return 0xF0FF, then 0xF00F (instret_inc held low).
- Illegal:
  - Stimulus: write to 0xC00, then read 0x7FF.
  - Response: `illegal` = 1 and `rdata` = 0 for both; cycle unaffected.
- HPM:
  - With `CSR_HPM_EN` and NUM_HPM = 2: pulse `hpm_event[1]` 3 times, read 0xB04 → 3.
  - Read 0xB05 → 0; write 0xB05 = 5, then read → 0.
  - Without the macro: 0xB04 → 0.
- Reset mid-access: assert `reset` in the cycle after a write to 0xB02. Next read returns 0 and `illegal` = 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the counter CSR file: CSR addresses, access
// operation encoding, mcountinhibit bit positions and the read-modify-write
// helper used by the top level.
package csr_pkg;

  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01,
    SET   = 2'b10,
    CLEAR = 2'b11
  } csr_op_e;

  // Machine-mode counters, low halves
  localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3   = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTER31  = 12'hB1F;
  // Machine-mode counters, high halves
  localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH      = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3H  = 12'hB83;
  localparam logic [11:0] CSR_MHPMCOUNTER31H = 12'hB9F;
  // Counter inhibit
  localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
  // User-mode read-only aliases
  localparam logic [11:0] CSR_CYCLE          = 12'hC00;
  localparam logic [11:0] CSR_TIME           = 12'hC01;
  localparam logic [11:0] CSR_INSTRET        = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER3    = 12'hC03;
  localparam logic [11:0] CSR_HPMCOUNTER31   = 12'hC1F;
  localparam logic [11:0] CSR_CYCLEH         = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH       = 12'hC82;
  localparam logic [11:0] CSR_HPMCOUNTER3H   = 12'hC83;
  localparam logic [11:0] CSR_HPMCOUNTER31H  = 12'hC9F;

  // Counter index inside a 32-entry bank; also the mcountinhibit bit index
  localparam int IDX_CYCLE    = 0;
  localparam int IDX_TIME     = 1;
  localparam int IDX_INSTRET  = 2;
  localparam int IDX_HPM_BASE = 3;
  localparam int MAX_HPM      = 29;

  localparam int INH_CY       = IDX_CYCLE;
  localparam int INH_IR       = IDX_INSTRET;
  localparam int INH_HPM_BASE = IDX_HPM_BASE;

  // New CSR value for a write/set/clear; READ returns the old value unchanged
  function automatic logic [31:0] csr_alu(input csr_op_e op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] operand);
    case (op)
      WRITE:   return operand;
      SET:     return old_val | operand;
      CLEAR:   return old_val & ~operand;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter_file_if.sv
// CSR access port between decode/execute and the counter CSR file.
// The master drives the access and the event strobes; the slave answers
// with registered read data and the illegal-access flag one cycle later.
interface csr_counter_file_if #(
  parameter int NUM_HPM = 4
);
  // Keeps the strobe vector legal when no hpm counters are configured
  localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;

  logic             csr_en;
  logic [11:0]      csr_addr;
  logic [1:0]       csr_op;
  logic [31:0]      csr_wdata;
  logic             instret_inc;
  logic [HPM_W-1:0] hpm_event;
  logic [31:0]      rdata;
  logic             illegal;

  modport master (
    output csr_en, csr_addr, csr_op, csr_wdata, instret_inc, hpm_event,
    input  rdata, illegal
  );

  modport slave (
    input  csr_en, csr_addr, csr_op, csr_wdata, instret_inc, hpm_event,
    output rdata, illegal
  );
endinterface

// File: rtl/csr_counter.sv
// One free-running CSR counter of WIDTH bits (33..64) with separately
// writable low and high 32-bit halves. A write in a cycle replaces that
// cycle's increment; the inhibit input only freezes counting.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] wr_value;

  // Merge the written half into the current value
  always_comb begin
    wr_value = count;
    if (wr_lo) wr_value[31:0] = wdata;
    if (wr_hi) wr_value[WIDTH-1:32] = wdata[WIDTH-33:0];
  end

  // Counter register: reset, then write, then increment
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      count <= wr_value;
    end else if (inc && !inhibit) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/csr_counter_file.sv
// RISC-V counter CSR file: mcycle, minstret, optional mhpmcounters,
// mcountinhibit and the user-mode read-only aliases.
// Build option: define CSR_HPM_EN to implement NUM_HPM hpm counters;
// otherwise every hpm address reads 0 and hpm_event is ignored.
module csr_counter_file
  import csr_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_HPM       = 4
) (
  input logic                clk,
  input logic                reset,
  csr_counter_file_if.slave  bus
);

`ifdef CSR_HPM_EN
  localparam int HPM_N = NUM_HPM;
`else
  localparam int HPM_N = 0;
`endif

  // Writable inhibit bits: cycle, instret and each implemented hpm counter
  localparam logic [31:0] INH_MASK =
    (32'(1) << INH_CY) | (32'(1) << INH_IR) |
    (((32'(1) << HPM_N) - 32'(1)) << INH_HPM_BASE);

  localparam logic [6:0] BANK_M_LO = CSR_MCYCLE[11:5];
  localparam logic [6:0] BANK_M_HI = CSR_MCYCLEH[11:5];
  localparam logic [6:0] BANK_U_LO = CSR_CYCLE[11:5];
  localparam logic [6:0] BANK_U_HI = CSR_CYCLEH[11:5];

  logic [COUNTER_WIDTH-1:0] cnt_val [0:31];
  logic [31:0]              inhibit_q;

  csr_op_e     op;
  logic [4:0]  idx;
  logic        hit_m_lo, hit_m_hi, hit_u_lo, hit_u_hi, hit_inh;
  logic        access_illegal;
  logic [63:0] cnt_sel;
  logic [31:0] old_val;
  logic [31:0] wr_val;
  logic        do_wr, wr_m_lo, wr_m_hi, wr_inh;

  // Address decode, read mux and the op ALU
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    op       = csr_op_e'(bus.csr_op);
    idx      = bus.csr_addr[4:0];
    hit_m_lo = 1'b0;
    hit_m_hi = 1'b0;
    hit_u_lo = 1'b0;
    hit_u_hi = 1'b0;
    hit_inh  = (bus.csr_addr == CSR_MCOUNTINHIBIT);
    // Index 1 (time) exists only as a user alias, not in machine space
    if (bus.csr_addr[11:5] == BANK_M_LO) hit_m_lo = (idx != 5'(IDX_TIME));
    if (bus.csr_addr[11:5] == BANK_M_HI) hit_m_hi = (idx != 5'(IDX_TIME));
    if (bus.csr_addr[11:5] == BANK_U_LO) hit_u_lo = 1'b1;
    if (bus.csr_addr[11:5] == BANK_U_HI) hit_u_hi = 1'b1;

    access_illegal = !(hit_m_lo || hit_m_hi || hit_u_lo || hit_u_hi || hit_inh) ||
                     ((hit_u_lo || hit_u_hi) && (op != READ));

    cnt_sel = 64'(cnt_val[idx]);
    old_val = '0;
    if (hit_inh)                    old_val = inhibit_q;
    else if (hit_m_lo || hit_u_lo)  old_val = cnt_sel[31:0];
    else if (hit_m_hi || hit_u_hi)  old_val = cnt_sel[63:32];

    wr_val  = csr_alu(op, old_val, bus.csr_wdata);
    do_wr   = bus.csr_en && !access_illegal && (op != READ);
    wr_m_lo = do_wr && hit_m_lo;
    wr_m_hi = do_wr && hit_m_hi;
    wr_inh  = do_wr && hit_inh;
  end

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_cycle (
    .clk     (clk),
    .reset   (reset),
    .inc     (1'b1),
    .inhibit (inhibit_q[INH_CY]),
    .wr_lo   (wr_m_lo && (idx == 5'(IDX_CYCLE))),
    .wr_hi   (wr_m_hi && (idx == 5'(IDX_CYCLE))),
    .wdata   (wr_val),
    .count   (cnt_val[IDX_CYCLE])
  );

  // time aliases cycle
  assign cnt_val[IDX_TIME] = cnt_val[IDX_CYCLE];

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_instret (
    .clk     (clk),
    .reset   (reset),
    .inc     (bus.instret_inc),
    .inhibit (inhibit_q[INH_IR]),
    .wr_lo   (wr_m_lo && (idx == 5'(IDX_INSTRET))),
    .wr_hi   (wr_m_hi && (idx == 5'(IDX_INSTRET))),
    .wdata   (wr_val),
    .count   (cnt_val[IDX_INSTRET])
  );

  for (genvar k = 0; k < MAX_HPM; k++) begin : g_hpm
    if (k < HPM_N) begin : g_impl
      csr_counter #(.WIDTH(COUNTER_WIDTH)) u_hpm (
        .clk     (clk),
        .reset   (reset),
        .inc     (bus.hpm_event[k]),
        .inhibit (inhibit_q[INH_HPM_BASE+k]),
        .wr_lo   (wr_m_lo && (idx == 5'(IDX_HPM_BASE + k))),
        .wr_hi   (wr_m_hi && (idx == 5'(IDX_HPM_BASE + k))),
        .wdata   (wr_val),
        .count   (cnt_val[IDX_HPM_BASE+k])
      );
    end else begin : g_absent
      assign cnt_val[IDX_HPM_BASE+k] = '0;
    end
  end

  if (HPM_N == 0) begin : g_no_hpm
    logic unused_hpm_event;
    assign unused_hpm_event = ^bus.hpm_event;
  end

  // mcountinhibit: only implemented counters have a storable bit
  always_ff @(posedge clk) begin
    if (reset) begin
      inhibit_q <= '0;
    end else if (wr_inh) begin
      inhibit_q <= wr_val & INH_MASK;
    end
  end

  // Registered response: pre-access value, zero on an illegal access
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata   <= '0;
      bus.illegal <= 1'b0;
    end else if (bus.csr_en) begin
      bus.rdata   <= access_illegal ? 32'h0 : old_val;
      bus.illegal <= access_illegal;
    end
  end

endmodule

// File: tb/tb_csr_counter_file.sv
// Directed self-checking bench for csr_counter_file (COUNTER_WIDTH 40,
// NUM_HPM 2). hpm expectations follow CSR_HPM_EN.
module tb_csr_counter_file;
  import csr_pkg::*;

  localparam int CW = 40;
  localparam int NH = 2;

`ifdef CSR_HPM_EN
  localparam logic [31:0] EXP_HPM1     = 32'd3;
  localparam logic [31:0] EXP_INH_MASK = 32'h0000_001D;
`else
  localparam logic [31:0] EXP_HPM1     = 32'd0;
  localparam logic [31:0] EXP_INH_MASK = 32'h0000_0005;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  csr_counter_file_if #(.NUM_HPM(NH)) bus ();

  csr_counter_file #(.COUNTER_WIDTH(CW), .NUM_HPM(NH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_resp(input string tag, input logic [31:0] exp_rdata,
                            input logic exp_illegal);
    check({tag, ".rdata"}, bus.rdata, exp_rdata);
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(exp_illegal));
  endtask

  // One CSR access: presented for one edge, then csr_en drops
  task automatic access(input csr_op_e op, input logic [11:0] addr,
                        input logic [31:0] wd);
    bus.csr_en    = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = addr;
    bus.csr_wdata = wd;
    tick();
    bus.csr_en    = 1'b0;
    bus.csr_op    = READ;
    bus.csr_wdata = '0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.csr_en      = 1'b0;
    bus.csr_op      = READ;
    bus.csr_addr    = '0;
    bus.csr_wdata   = '0;
    bus.instret_inc = 1'b0;
    bus.hpm_event   = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_resp("reset", 32'h0, 1'b0);

    // Counting: ten counting edges, then read cycle
    repeat (10) tick();
    access(READ, CSR_CYCLE, '0);
    check_resp("cycle_10", 32'd10, 1'b0);

    // Inhibit cycle; the write edge still counts (11 -> 12)
    access(WRITE, CSR_MCOUNTINHIBIT, 32'h1);
    check_resp("inh_wr", 32'h0, 1'b0);
    repeat (5) tick();
    access(READ, CSR_CYCLE, '0);
    check("inh_hold_a", bus.rdata, 32'd12);
    access(READ, CSR_CYCLE, '0);
    check("inh_hold_b", bus.rdata, 32'd12);
    access(READ, CSR_MCOUNTINHIBIT, '0);
    check("inh_rd", bus.rdata, 32'h1);
    access(WRITE, CSR_MCOUNTINHIBIT, 32'h0);
    check("inh_clr_old", bus.rdata, 32'h1);

    // Carry: low half all-ones, one counting edge, then high half = 1
    access(WRITE, CSR_MCYCLE, 32'hFFFF_FFFF);
    check("carry_wr_old", bus.rdata, 32'd12);
    tick();
    access(READ, CSR_MCYCLEH, '0);
    check_resp("carry_hi", 32'd1, 1'b0);
    access(READ, CSR_MCYCLE, '0);
    check("carry_lo", bus.rdata, 32'd1);

    // Write beats a same-cycle retire
    bus.instret_inc = 1'b1;
    access(WRITE, CSR_MINSTRET, 32'h100);
    bus.instret_inc = 1'b0;
    check("instret_old", bus.rdata, 32'h0);
    access(READ, CSR_MINSTRET, '0);
    check_resp("wr_beats_inc", 32'h100, 1'b0);

    // Set / clear
    access(WRITE, CSR_MINSTRET, 32'hF0F0);
    check("wr_f0f0_old", bus.rdata, 32'h100);
    access(SET, CSR_MINSTRET, 32'h000F);
    check("set_old", bus.rdata, 32'hF0F0);
    access(CLEAR, CSR_MINSTRET, 32'h00F0);
    check("clr_old", bus.rdata, 32'hF0FF);
    access(READ, CSR_MINSTRET, '0);
    check("clr_result", bus.rdata, 32'hF00F);

    // Four retires
    bus.instret_inc = 1'b1;
    repeat (4) tick();
    bus.instret_inc = 1'b0;
    access(READ, CSR_INSTRET, '0);
    check_resp("instret_cnt", 32'hF013, 1'b0);

    // High half of a 40-bit counter keeps only 8 bits
    access(WRITE, CSR_MINSTRETH, 32'hFFFF_FFFF);
    check("hi_wr_old", bus.rdata, 32'h0);
    access(READ, CSR_MINSTRETH, '0);
    check("hi_width", bus.rdata, 32'h0000_00FF);
    access(READ, CSR_MINSTRET, '0);
    check("hi_wr_lo_kept", bus.rdata, 32'hF013);

    // Known cycle value, then illegal accesses must not disturb it
    access(WRITE, CSR_MCYCLEH, 32'h0);
    check("cyh_old", bus.rdata, 32'd1);
    access(WRITE, CSR_MCYCLE, 32'h1000);
    check("cy_wr_legal", 32'(bus.illegal), 32'd0);
    access(WRITE, CSR_CYCLE, 32'h5555);
    check_resp("ill_user_wr", 32'h0, 1'b1);
    access(READ, 12'h7FF, '0);
    check_resp("ill_unmapped", 32'h0, 1'b1);
    access(READ, CSR_CYCLE, '0);
    check_resp("cy_unaffected", 32'h1002, 1'b0);
    access(READ, CSR_TIME, '0);
    check_resp("time_alias", 32'h1003, 1'b0);
    access(READ, 12'hB01, '0);
    check_resp("ill_b01", 32'h0, 1'b1);
    access(SET, CSR_INSTRET, 32'h1);
    check_resp("ill_user_set", 32'h0, 1'b1);
    access(READ, CSR_CYCLEH, '0);
    check_resp("cycleh_alias", 32'h0, 1'b0);

    // Inhibit bits that do not exist are hardwired zero
    access(WRITE, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
    check("mask_wr_old", bus.rdata, 32'h0);
    access(READ, CSR_MCOUNTINHIBIT, '0);
    check("inh_mask", bus.rdata, EXP_INH_MASK);
    access(WRITE, CSR_MCOUNTINHIBIT, 32'h0);
    check("mask_clr_old", bus.rdata, EXP_INH_MASK);

    // HPM: three events on counter 4, counter 5 is unimplemented
    bus.hpm_event = 2'b10;
    repeat (3) tick();
    bus.hpm_event = 2'b00;
    access(READ, 12'hB04, '0);
    check_resp("hpm4", EXP_HPM1, 1'b0);
    access(READ, 12'hB03, '0);
    check("hpm3_idle", bus.rdata, 32'h0);
    access(READ, 12'hC04, '0);
    check_resp("hpm4_alias", EXP_HPM1, 1'b0);
    access(WRITE, 12'hB05, 32'd5);
    check_resp("hpm5_wr", 32'h0, 1'b0);
    access(READ, 12'hB05, '0);
    check_resp("hpm5_rd", 32'h0, 1'b0);

    // Reset right after a write; an access during reset does not complete
    access(WRITE, CSR_MINSTRET, 32'h1234);
    reset = 1'b1;
    access(READ, 12'h7FF, '0);
    reset = 1'b0;
    check_resp("reset_mid", 32'h0, 1'b0);
    access(READ, CSR_MINSTRET, '0);
    check_resp("after_reset", 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
